// File: rtl/flag_display_scan.sv
// flag_display_scan: samples N_FLAGS ALU status flags into optional sticky
// latches, marks newly raised flags for blinking, and drives N_FLAGS+1
// multiplexed seven-segment digits (flag digits plus an 'F' label digit)
// with an integrated scan counter and per-slot anti-ghost blanking.
module flag_display_scan #(
  parameter int unsigned N_FLAGS   = 3,
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned BLINK_DIV = 25000000,
  parameter int unsigned STICKY    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FLAGS-1:0] flags,
  input  logic               flag_valid,
  input  logic               clr,
  input  logic               blink_en,
  output logic [N_FLAGS-1:0] sticky_q,
  output logic [N_FLAGS:0]   an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int unsigned SW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned DW = $clog2(N_FLAGS + 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_ONE  = 7'b1111001;
  localparam logic [6:0] SEG_F    = 7'b0001110;

  if (BLANK_CYC >= CLK_DIV || N_FLAGS < 1 || N_FLAGS > 7) begin : g_param_check
    $fatal(1, "flag_display_scan: need BLANK_CYC < CLK_DIV and 1 <= N_FLAGS <= 7");
  end

  // What the current slot is showing, decoded from the scan counters.
  typedef enum logic [1:0] {
    PH_BLANK,
    PH_FLAG,
    PH_LABEL
  } phase_e;

  logic [SW-1:0]      slot_cnt;
  logic [DW-1:0]      dig_idx;
  logic [BW-1:0]      blink_cnt;
  logic               blink_ph;
  logic [N_FLAGS-1:0] new_q;

  logic [N_FLAGS-1:0] base_s;
  logic [N_FLAGS-1:0] base_n;
  logic [N_FLAGS-1:0] sticky_n;
  logic [N_FLAGS-1:0] new_n;

  phase_e             phase;
  logic               cur_flag;
  logic               cur_new;
  logic [N_FLAGS:0]   an_n;
  logic [6:0]         seg_n;
  logic               dp_n;

  logic               slot_wrap;
  logic               dig_wrap;
  logic               blink_wrap;

  // Next flag state: clr wipes the old state before any same-cycle load, so a
  // combined clr+flag_valid behaves as a fresh load and marks all loaded bits new.
  always_comb begin
    base_s   = clr ? '0 : sticky_q;
    base_n   = clr ? '0 : new_q;
    sticky_n = base_s;
    if (flag_valid) begin
      sticky_n = (STICKY != 0) ? (base_s | flags) : flags;
    end
    new_n = base_n | (sticky_n & ~base_s);
  end

  // Flag latches and new-flag markers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= '0;
      new_q    <= '0;
    end else begin
      sticky_q <= sticky_n;
      new_q    <= new_n;
    end
  end

  assign slot_wrap  = (slot_cnt  == SW'(CLK_DIV - 1));
  assign dig_wrap   = (dig_idx   == DW'(N_FLAGS));
  assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

  // Scan counters: slot_cnt runs through one digit slot, dig_idx steps digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      dig_idx  <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      dig_idx  <= dig_wrap ? '0 : dig_idx + DW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  // Free-running blink timer; phase starts visible and flips on every wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
    end else if (blink_wrap) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Select the flag and new marker of the digit currently being scanned.
  always_comb begin
    cur_flag = 1'b0;
    cur_new  = 1'b0;
    for (int unsigned i = 0; i < N_FLAGS; i++) begin
      if (DW'(i) == dig_idx) begin
        cur_flag = sticky_q[i];
        cur_new  = new_q[i];
      end
    end
  end

  // Classify the current slot position.
  always_comb begin
    if (slot_cnt < SW'(BLANK_CYC)) begin
      phase = PH_BLANK;
    end else if (dig_wrap) begin
      phase = PH_LABEL;
    end else begin
      phase = PH_FLAG;
    end
  end

  // Display decode for the next registered output value.
  always_comb begin
    an_n  = '1;
    seg_n = SEG_OFF;
    dp_n  = 1'b1;
    if (phase != PH_BLANK) begin
      for (int unsigned i = 0; i <= N_FLAGS; i++) begin
        an_n[i] = (DW'(i) != dig_idx);
      end
    end
    case (phase)
      PH_FLAG: begin
        seg_n = cur_flag ? SEG_ONE : SEG_ZERO;
        if (blink_en && cur_new && !blink_ph) begin
          seg_n = SEG_OFF;
        end
      end
      PH_LABEL: begin
        seg_n = SEG_F;
        dp_n  = ~(|sticky_q);
      end
      default: begin
        seg_n = SEG_OFF;
      end
    endcase
  end

  // Registered display pins, one cycle behind the counter decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_n;
      seg <= seg_n;
      dp  <= dp_n;
    end
  end

endmodule

// File: tb/tb_flag_display_scan.sv
// Bench for flag_display_scan (N_FLAGS=3, CLK_DIV=8, BLANK_CYC=2,
// BLINK_DIV=16, STICKY=1). A reference model predicts the registered pins and
// sticky_q at each rising edge and queues them; they are compared on the
// following falling edge.
module tb_flag_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] flags = 3'b000;
  logic       flag_valid = 1'b0;
  logic       clr = 1'b0;
  logic       blink_en = 1'b0;
  logic [2:0] sticky_q;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] stk;
  } exp_t;

  exp_t sb[$];

  int         s = 0;
  logic [2:0] m_stk = 3'b000;
  logic [2:0] m_new = 3'b000;

  always #5 clk = ~clk;

  flag_display_scan #(
    .N_FLAGS  (3),
    .CLK_DIV  (8),
    .BLANK_CYC(2),
    .BLINK_DIV(16),
    .STICKY   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flags     (flags),
    .flag_valid(flag_valid),
    .clr       (clr),
    .blink_en  (blink_en),
    .sticky_q  (sticky_q),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: predict outputs registered at this edge, then advance.
  always @(posedge clk) begin : model
    exp_t       e;
    int         slot;
    int         dig;
    bit         vis;
    logic [2:0] old_stk;
    if (!rst) begin
      s     = 0;
      m_stk = 3'b000;
      m_new = 3'b000;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.stk = 3'b000;
    end else begin
      slot  = s % 8;
      dig   = (s / 8) % 4;
      vis   = ((s / 16) % 2) == 0;
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      if (slot >= 2) begin
        e.an[dig] = 1'b0;
        if (dig == 3) begin
          e.seg = 7'b0001110;
          e.dp  = (m_stk == 3'b000);
        end else if (blink_en && m_new[dig] && !vis) begin
          e.seg = 7'h7F;
        end else begin
          e.seg = m_stk[dig] ? 7'b1111001 : 7'b1000000;
        end
      end
      old_stk = m_stk;
      if (clr && flag_valid) begin
        m_stk = flags;
        m_new = flags;
      end else if (clr) begin
        m_stk = 3'b000;
        m_new = 3'b000;
      end else if (flag_valid) begin
        m_stk = old_stk | flags;
        m_new = m_new | (m_stk & ~old_stk);
      end
      e.stk = m_stk;
      s++;
    end
    sb.push_back(e);
  end

  // Compare predictions against the DUT away from the active edge.
  always @(negedge clk) begin : scoreboard
    exp_t g;
    if (sb.size() > 0) begin
      g = sb.pop_front();
      check("an", 32'(an), 32'(g.an));
      check("seg", 32'(seg), 32'(g.seg));
      check("dp", 32'(dp), 32'(g.dp));
      check("sticky_q", 32'(sticky_q), 32'(g.stk));
    end
  end

  // An asynchronous reset invalidates any pending predictions.
  always @(negedge rst) sb.delete();

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [2:0] f, input logic c);
    flags      = f;
    flag_valid = 1'b1;
    clr        = c;
    tick(1);
    flag_valid = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin : stim
    int guard;
    // Reset held, then released: blank window then digit 0.
    tick(3);
    rst = 1'b1;
    // Free scan, no flags.
    tick(40);
    // Sticky latching then clear.
    load(3'b001, 1'b0);
    load(3'b000, 1'b0);
    tick(40);
    pulse_clr();
    tick(32);
    // clr and flag_valid together after 101.
    load(3'b101, 1'b0);
    tick(2);
    load(3'b010, 1'b1);
    tick(32);
    // Blink of a newly raised flag, steady after clr, re-trigger afterwards.
    pulse_clr();
    blink_en = 1'b1;
    load(3'b010, 1'b0);
    tick(80);
    pulse_clr();
    tick(40);
    load(3'b010, 1'b0);
    tick(80);
    blink_en = 1'b0;
    // Reset during digit 2's active window with all flags set.
    load(3'b111, 1'b0);
    guard = 0;
    while (!((((s - 1) % 32) >= 18) && (((s - 1) % 32) <= 23)) && guard < 64) begin
      tick(1);
      guard++;
    end
    check("dig2_wait_in_bound", 32'(guard < 64), 32'd1);
    check("pre_rst_an", 32'(an), 32'(4'b1011));
    #1;
    rst = 1'b0;
    #1;
    check("async_an", 32'(an), 32'(4'b1111));
    check("async_seg", 32'(seg), 32'(7'h7F));
    check("async_dp", 32'(dp), 32'd1);
    check("async_sticky", 32'(sticky_q), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
